// File: rtl/bsram_word_bridge_if.sv
// CPU-side word bus of the block-RAM bridge: request and response each use a valid/ready handshake.
// The slave modport is the bridge view. The master modport is the CPU view.
interface bsram_word_bridge_if #(
  parameter int ADDR_W = 15
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-2:0] req_waddr;
  logic [15:0]       req_wdata;
  logic [1:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_rdata;

  modport slave (
    input  req_valid, req_we, req_waddr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

  modport master (
    output req_valid, req_we, req_waddr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bsram_word_bridge.sv
// Splits each 16-bit CPU word access into two little-endian byte accesses on a 32Kx8 block RAM.
// Ack latency is 2 clocks for writes and 2+RD_LAT for reads; the response is held until rsp_ready.
module bsram_word_bridge #(
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  bsram_word_bridge_if.slave cpu,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_RD_WAIT, S_WR_LO, S_WR_HI, S_RESP
  } state_t;

  localparam logic LAST_WAIT = (RD_LAT == 2);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-2:0] r_waddr;
  logic [15:0]       r_wdata;
  logic [1:0]        r_be;
  logic [7:0]        r_lo_byte;
  logic              r_wait_cnt;
  logic              r_rsp_valid;
  logic [15:0]       r_rsp_rdata;
  logic              w_lo_cap;
  logic              w_hi_cap;

  // The high byte lands RD_LAT edges after RD_HI; the low byte one edge earlier.
  assign w_hi_cap = (r_state == S_RD_WAIT) && (r_wait_cnt == LAST_WAIT);
  assign w_lo_cap = (RD_LAT == 1) ? (r_state == S_RD_HI)
                                  : ((r_state == S_RD_WAIT) && !r_wait_cnt);

  assign cpu.req_ready = (r_state == S_IDLE);
  assign cpu.rsp_valid = r_rsp_valid;
  assign cpu.rsp_rdata = r_rsp_rdata;
  assign ram_oce       = 1'b1;
  assign ram_reset     = reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_lo_byte   <= '0;
      r_wait_cnt  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && cpu.req_valid) begin
        r_waddr <= cpu.req_waddr;
        r_wdata <= cpu.req_wdata;
        r_be    <= cpu.req_be;
      end
      r_wait_cnt <= (r_state == S_RD_WAIT) ? r_wait_cnt + 1'b1 : 1'b0;
      if (w_lo_cap) r_lo_byte <= ram_dout;
      if (w_hi_cap) begin
        r_rsp_rdata <= {ram_dout, r_lo_byte};
        r_rsp_valid <= 1'b1;
      end else if (r_state == S_WR_HI) begin
        r_rsp_rdata <= '0;
        r_rsp_valid <= 1'b1;
      end else if (r_state == S_RESP && cpu.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Write strobes follow the byte enables so a disabled byte never sees ce with wre.
  always_comb begin
    w_next  = r_state;
    ram_ce  = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    case (r_state)
      S_IDLE: begin
        if (cpu.req_valid) w_next = cpu.req_we ? S_WR_LO : S_RD_LO;
      end
      S_RD_LO: begin
        ram_ce = 1'b1;
        ram_ad = {r_waddr, 1'b0};
        w_next = S_RD_HI;
      end
      S_RD_HI: begin
        ram_ce = 1'b1;
        ram_ad = {r_waddr, 1'b1};
        w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (w_hi_cap) w_next = S_RESP;
      end
      S_WR_LO: begin
        ram_ce  = r_be[0];
        ram_wre = r_be[0];
        ram_ad  = {r_waddr, 1'b0};
        ram_din = r_wdata[7:0];
        w_next  = S_WR_HI;
      end
      S_WR_HI: begin
        ram_ce  = r_be[1];
        ram_wre = r_be[1];
        ram_ad  = {r_waddr, 1'b1};
        ram_din = r_wdata[15:8];
        w_next  = S_RESP;
      end
      S_RESP: begin
        if (cpu.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bsram_word_bridge.sv
// Bench for bsram_word_bridge: behavioural 32Kx8 RAM, byte shadow model and response scoreboard.
module tb_bsram_word_bridge;
  localparam int ADDR_W = 15;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bsram_word_bridge_if #(.ADDR_W(ADDR_W)) cpu_if();

  logic              ram_ce, ram_oce, ram_wre, ram_reset;
  logic [ADDR_W-1:0] ram_ad;
  logic [7:0]        ram_din, ram_dout;

  bsram_word_bridge #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu      (cpu_if.slave),
    .ram_ce   (ram_ce),
    .ram_oce  (ram_oce),
    .ram_wre  (ram_wre),
    .ram_reset(ram_reset),
    .ram_ad   (ram_ad),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Behavioural block RAM: bypass read (RD_LAT=1) or registered output (RD_LAT=2).
  logic [7:0] mem [0:32767];
  logic [7:0] rd_q1, rd_q2;
  always @(posedge clk) begin
    if (ram_ce && ram_wre) mem[ram_ad] <= ram_din;
    if (ram_reset)                 rd_q1 <= 8'h00;
    else if (ram_ce && !ram_wre)   rd_q1 <= mem[ram_ad];
    rd_q2 <= ram_reset ? 8'h00 : rd_q1;
  end
  assign ram_dout = (RD_LAT == 1) ? rd_q1 : rd_q2;

  int wr_strobes = 0;
  always @(posedge clk) if (ram_ce && ram_wre) wr_strobes = wr_strobes + 1;

  logic [7:0] shadow [0:32767];

  typedef struct {
    logic [15:0] data;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_txn(input logic we, input logic [13:0] wa, input logic [15:0] wd,
                         input logic [1:0] be, input int hold);
    int   n;
    int   s0;
    exp_t e;
    exp_t g;
    @(negedge clk);
    check_val("req_ready_idle", cpu_if.req_ready, 1);
    cpu_if.req_valid = 1'b1;
    cpu_if.req_we    = we;
    cpu_if.req_waddr = wa;
    cpu_if.req_wdata = wd;
    cpu_if.req_be    = be;
    s0 = wr_strobes;
    @(posedge clk);
    e.data = we ? 16'h0000 : {shadow[{wa, 1'b1}], shadow[{wa, 1'b0}]};
    e.lat  = we ? 2 : 2 + RD_LAT;
    exp_q.push_back(e);
    if (we && be[0]) shadow[{wa, 1'b0}] = wd[7:0];
    if (we && be[1]) shadow[{wa, 1'b1}] = wd[15:8];
    @(negedge clk);
    // Scramble the request fields: they must not affect an accepted transaction.
    cpu_if.req_valid = 1'b0;
    cpu_if.req_we    = 1'($urandom);
    cpu_if.req_waddr = 14'($urandom);
    cpu_if.req_wdata = 16'($urandom);
    cpu_if.req_be    = 2'($urandom);
    n = 0;
    while (!cpu_if.rsp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    g = exp_q.pop_front();
    if (!cpu_if.rsp_valid) begin
      check_val("rsp_timeout", 0, 1);
      return;
    end
    check_val(we ? "wr_ack_latency" : "rd_latency", n, g.lat);
    check_val(we ? "wr_ack_data" : "rd_data", cpu_if.rsp_rdata, g.data);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_valid", cpu_if.rsp_valid, 1);
      check_val("hold_data", cpu_if.rsp_rdata, g.data);
      check_val("hold_req_ready", cpu_if.req_ready, 0);
    end
    if (we) check_val("wr_strobe_count", wr_strobes - s0, $countones(be));
    cpu_if.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_if.rsp_ready = 1'b0;
    check_val("rsp_valid_after_hs", cpu_if.rsp_valid, 0);
    check_val("req_ready_after_hs", cpu_if.req_ready, 1);
  endtask

  task automatic reset_mid_read(input logic [13:0] wa);
    int seen;
    @(negedge clk);
    cpu_if.req_valid = 1'b1;
    cpu_if.req_we    = 1'b0;
    cpu_if.req_waddr = wa;
    @(posedge clk);
    @(negedge clk);
    cpu_if.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("rd_hi_ce", ram_ce, 1);
    check_val("rd_hi_ad", 32'(ram_ad), 32'({wa, 1'b1}));
    reset = 1'b1;
    #1;
    check_val("rst_rsp_valid", cpu_if.rsp_valid, 0);
    check_val("rst_ram_ce", ram_ce, 0);
    check_val("rst_ram_wre", ram_wre, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rst_req_ready", cpu_if.req_ready, 1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_if.rsp_valid) seen++;
    end
    check_val("rst_no_response", seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    cpu_if.req_valid = 1'b0;
    cpu_if.req_we    = 1'b0;
    cpu_if.req_waddr = '0;
    cpu_if.req_wdata = '0;
    cpu_if.req_be    = '0;
    cpu_if.rsp_ready = 1'b0;
    #1;
    check_val("reset_rsp_valid", cpu_if.rsp_valid, 0);
    check_val("reset_rsp_rdata", cpu_if.rsp_rdata, 0);
    check_val("reset_req_ready", cpu_if.req_ready, 1);
    check_val("reset_ram_ce", ram_ce, 0);
    check_val("reset_ram_wre", ram_wre, 0);
    check_val("reset_ram_ad", 32'(ram_ad), 0);
    check_val("reset_ram_din", ram_din, 0);
    check_val("ram_oce_tied", ram_oce, 1);
    check_val("ram_reset_follows", ram_reset, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_txn(1'b1, 14'h0005, 16'hBEEF, 2'b11, 0);
    check_val("mem_byte10", mem[10], 8'hEF);
    check_val("mem_byte11", mem[11], 8'hBE);
    run_txn(1'b0, 14'h0005, 16'h0000, 2'b00, 0);

    reset_mid_read(14'h0005);
    run_txn(1'b0, 14'h0005, 16'h0000, 2'b00, 0);

    run_txn(1'b1, 14'h0009, 16'h1234, 2'b11, 0);
    run_txn(1'b1, 14'h0009, 16'hABCD, 2'b10, 0);
    run_txn(1'b0, 14'h0009, 16'h0000, 2'b00, 0);
    check_val("partial_write_word", {mem[19], mem[18]}, 16'hAB34);
    run_txn(1'b1, 14'h0009, 16'hFFFF, 2'b00, 0);
    run_txn(1'b0, 14'h0009, 16'h0000, 2'b00, 0);
    run_txn(1'b1, 14'h0009, 16'h7788, 2'b01, 0);
    run_txn(1'b0, 14'h0009, 16'h0000, 2'b00, 0);

    run_txn(1'b1, 14'h0020, 16'hCAFE, 2'b11, 0);
    run_txn(1'b0, 14'h0020, 16'h0000, 2'b00, 5);

    run_txn(1'b1, 14'h1FFF, 16'h55AA, 2'b11, 0);
    run_txn(1'b1, 14'h2000, 16'h66BB, 2'b11, 0);
    for (int k = 0; k < 4; k++)
      run_txn(1'b0, (k % 2 == 0) ? 14'h1FFF : 14'h2000, 16'h0000, 2'b00, k);

    run_txn(1'b1, 14'h3FFF, 16'h1357, 2'b11, 1);
    run_txn(1'b0, 14'h3FFF, 16'h0000, 2'b00, 0);
    check_val("top_byte_lo", mem[32766], 8'h57);
    check_val("top_byte_hi", mem[32767], 8'h13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
